// File: rtl/servo_seq_pkg.sv
// Shared state encodings and settle-time constants for the servo move sequencer.
package servo_seq_pkg;

    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] ESPERA  = 3'd1;
    localparam logic [2:0] RETORNO = 3'd2;
    localparam logic [2:0] FIM     = 3'd3;

    localparam int unsigned T_ASSENTA_500MS = 25_000_000;
    localparam int unsigned T_ASSENTA_SIM   = 4;

endpackage

// File: rtl/sequenciador_servo_contador.sv
// Modulo-M settle timer: counts while conta=1, flags the last count, limpa has priority.
module contador_m #(
    parameter int unsigned M = 4,
    parameter int unsigned W = $clog2(M + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] valor_q, valor_d;

    always_comb begin
        valor_d = valor_q;
        if (limpa) begin
            valor_d = '0;
        end else if (conta) begin
            valor_d = (valor_q == ULTIMO) ? '0 : valor_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign fim = (valor_q == ULTIMO);

endmodule

// File: rtl/sequenciador_servo.sv
// Servo move sequencer: start pulse + target in, posicao command out, busy while settling.
// Optional return-to-rest phase enabled by defining SERVO_SEQ_RETORNO_EN.
module sequenciador_servo
    import servo_seq_pkg::*;
#(
    parameter int unsigned T_ASSENTA   = T_ASSENTA_500MS,
    parameter logic        POS_REPOUSO = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       destino,
    output logic       posicao,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    // Handshake: iniciar/destino are taken only in OCIOSO; ocupado covers the settle
    // phase(s) and pronto pulses one cycle in FIM. Requests outside OCIOSO are dropped.
    logic [2:0] estado_q, estado_d;
    logic       posicao_q, posicao_d;
    logic       ocupado_q, pronto_q;
    logic       limpa, conta, fim_contagem;

    contador_m #(
        .M (T_ASSENTA)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .limpa (limpa),
        .conta (conta),
        .fim   (fim_contagem)
    );

    always_comb begin
        estado_d  = estado_q;
        posicao_d = posicao_q;
        limpa     = 1'b0;
        conta     = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    if (destino != posicao_q) begin
                        posicao_d = destino;
                        limpa     = 1'b1;
                        estado_d  = ESPERA;
                    end else begin
                        estado_d  = FIM;
                    end
                end
            end
            ESPERA: begin
                conta = 1'b1;
                if (fim_contagem) begin
`ifdef SERVO_SEQ_RETORNO_EN
                    if (posicao_q != POS_REPOUSO) begin
                        posicao_d = POS_REPOUSO;
                        limpa     = 1'b1;
                        estado_d  = RETORNO;
                    end else begin
                        estado_d  = FIM;
                    end
`else
                    estado_d = FIM;
`endif
                end
            end
`ifdef SERVO_SEQ_RETORNO_EN
            RETORNO: begin
                conta = 1'b1;
                if (fim_contagem) begin
                    estado_d = FIM;
                end
            end
`endif
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // Moore outputs are registered from the next state so they align with estado_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            posicao_q <= POS_REPOUSO;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            posicao_q <= posicao_d;
            ocupado_q <= (estado_d == ESPERA) || (estado_d == RETORNO);
            pronto_q  <= (estado_d == FIM);
        end
    end

    assign posicao   = posicao_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_servo.sv
// Directed bench for sequenciador_servo with T_ASSENTA=4, POS_REPOUSO=0.
module tb_sequenciador_servo;

    localparam int T = 4;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       destino;
    logic       posicao;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    int  n_checks = 0;
    int  n_fail   = 0;
    logic exp_pos = 1'b0;

    sequenciador_servo #(
        .T_ASSENTA   (T),
        .POS_REPOUSO (1'b0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .destino   (destino),
        .posicao   (posicao),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit has_retorno(input logic dest, input logic cur);
`ifdef SERVO_SEQ_RETORNO_EN
        return (dest != cur) && (dest != 1'b0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset;
        #3 reset = 1'b0;
        #1;
        n_checks++; if (posicao !== 1'b0)   begin n_fail++; $display("FAIL reset posicao got %b exp 0", posicao); end
        n_checks++; if (ocupado !== 1'b0)   begin n_fail++; $display("FAIL reset ocupado got %b exp 0", ocupado); end
        n_checks++; if (pronto !== 1'b0)    begin n_fail++; $display("FAIL reset pronto got %b exp 0", pronto); end
        n_checks++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL reset db_estado got %0d exp 0", db_estado); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        exp_pos = 1'b0;
    endtask

    // Walks the whole move timeline; sample i is taken after edge k+i.
    task automatic test_move(input logic dest);
        bit   real_mv, ret;
        int   len;
        logic e_pronto, e_ocup, e_pos;
        logic [2:0] e_est;
        real_mv = (dest != exp_pos);
        ret     = has_retorno(dest, exp_pos);
        len     = !real_mv ? 0 : (ret ? 2 * T : T);
        @(negedge clock);
        iniciar = 1'b1;
        destino = dest;
        for (int i = 0; i <= len + 1; i++) begin
            @(negedge clock);
            iniciar  = 1'b0;
            destino  = ~dest;
            e_pronto = (i == len);
            e_ocup   = (i < len);
            e_est    = (i < len) ? ((i < T) ? 3'd1 : 3'd2) : ((i == len) ? 3'd3 : 3'd0);
            e_pos    = !real_mv ? exp_pos : ((ret && i >= T) ? 1'b0 : dest);
            n_checks++; if (pronto !== e_pronto) begin n_fail++; $display("FAIL move(%b) i=%0d pronto got %b exp %b", dest, i, pronto, e_pronto); end
            n_checks++; if (ocupado !== e_ocup)  begin n_fail++; $display("FAIL move(%b) i=%0d ocupado got %b exp %b", dest, i, ocupado, e_ocup); end
            n_checks++; if (db_estado !== e_est) begin n_fail++; $display("FAIL move(%b) i=%0d db_estado got %0d exp %0d", dest, i, db_estado, e_est); end
            n_checks++; if (posicao !== e_pos)   begin n_fail++; $display("FAIL move(%b) i=%0d posicao got %b exp %b", dest, i, posicao, e_pos); end
        end
        if (real_mv) exp_pos = ret ? 1'b0 : dest;
    endtask

    task automatic test_ignored_start;
        logic dest, e_pos, fin;
        bit   ret;
        int   len, n_pronto;
        dest     = ~exp_pos;
        ret      = has_retorno(dest, exp_pos);
        len      = ret ? 2 * T : T;
        fin      = ret ? 1'b0 : dest;
        n_pronto = 0;
        @(negedge clock);
        iniciar = 1'b1;
        destino = dest;
        for (int i = 0; i <= len; i++) begin
            @(negedge clock);
            e_pos = (ret && i >= T) ? 1'b0 : dest;
            n_checks++; if (posicao !== e_pos) begin n_fail++; $display("FAIL ignored i=%0d posicao got %b exp %b", i, posicao, e_pos); end
            if (pronto === 1'b1) n_pronto++;
            destino = ~destino;
        end
        n_checks++; if (n_pronto !== 1) begin n_fail++; $display("FAIL ignored pronto_count got %0d exp 1", n_pronto); end
        @(negedge clock);
        n_checks++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL ignored in_fim db_estado got %0d exp 0", db_estado); end
        n_checks++; if (pronto !== 1'b0)    begin n_fail++; $display("FAIL ignored in_fim pronto got %b exp 0", pronto); end
        destino = fin;
        @(negedge clock);
        iniciar = 1'b0;
        n_checks++; if (db_estado !== 3'd3) begin n_fail++; $display("FAIL ignored reaccept db_estado got %0d exp 3", db_estado); end
        n_checks++; if (pronto !== 1'b1)    begin n_fail++; $display("FAIL ignored reaccept pronto got %b exp 1", pronto); end
        n_checks++; if (posicao !== fin)    begin n_fail++; $display("FAIL ignored reaccept posicao got %b exp %b", posicao, fin); end
        exp_pos = fin;
        @(negedge clock);
        n_checks++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL ignored idle db_estado got %0d exp 0", db_estado); end
    endtask

    task automatic test_reset_abort;
        logic dest;
        dest = ~exp_pos;
        @(negedge clock);
        iniciar = 1'b1;
        destino = dest;
        @(negedge clock);
        iniciar = 1'b0;
        n_checks++; if (db_estado !== 3'd1) begin n_fail++; $display("FAIL abort start db_estado got %0d exp 1", db_estado); end
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (posicao !== 1'b0)   begin n_fail++; $display("FAIL abort posicao got %b exp 0", posicao); end
        n_checks++; if (ocupado !== 1'b0)   begin n_fail++; $display("FAIL abort ocupado got %b exp 0", ocupado); end
        n_checks++; if (pronto !== 1'b0)    begin n_fail++; $display("FAIL abort pronto got %b exp 0", pronto); end
        n_checks++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL abort db_estado got %0d exp 0", db_estado); end
        @(negedge clock);
        reset   = 1'b1;
        exp_pos = 1'b0;
        for (int i = 0; i < 2 * T + 2; i++) begin
            @(negedge clock);
            n_checks++; if (pronto !== 1'b0)    begin n_fail++; $display("FAIL abort after i=%0d pronto got %b exp 0", i, pronto); end
            n_checks++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL abort after i=%0d db_estado got %0d exp 0", i, db_estado); end
        end
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        destino = 1'b0;
        test_reset();
        test_move(1'b0);
        test_move(1'b1);
        test_move(1'b1);
        test_move(1'b0);
        test_ignored_start();
        test_reset_abort();
        test_move(1'b1);
        test_move(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
